// File: rtl/alu_ctrl_decode_stage.sv
// alu_ctrl_decode_stage
// Decodes the MIPS opcode/funct in ID into a 3-bit ALU op plus EX control.
// The result is registered into the ID/EX pipeline register, with the
// hazard-unit stall and flush applied. A saturating counter tracks how many
// illegal encodings reached EX.
//
// Valid semantics: valid_d marks a real instruction in ID and valid_e marks
// a real instruction in EX. There is no ready path; the hazard unit applies
// back-pressure through stall and cancels instructions through flush.
// The per-edge priority is rst > flush > stall > load. A load with
// valid_d=0 writes a bubble.
module alu_ctrl_decode_stage #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode_d,
    input  logic [5:0]       funct_d,
    input  logic             valid_d,
    input  logic             stall,
    input  logic             flush,
    output logic [2:0]       alu_control_e,
    output logic             alu_src_e,
    output logic             reg_write_e,
    output logic             valid_e,
    output logic             illegal_e,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_NOR  = 3'b101;
    localparam logic [2:0] OP_SLT  = 3'b110;
    localparam logic [2:0] OP_SLTU = 3'b111;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [2:0] dec_ctrl;
    logic       dec_src;
    logic       dec_rw;
    logic       dec_ill;

    // Combinational decode of the ID instruction; unlisted encodings are flagged illegal.
    always_comb begin
        dec_ctrl = OP_ADD;
        dec_src  = 1'b0;
        dec_rw   = 1'b0;
        dec_ill  = 1'b0;
        case (opcode_d)
            6'h00: begin
                dec_rw = 1'b1;
                case (funct_d)
                    6'h20, 6'h21: dec_ctrl = OP_ADD;
                    6'h22, 6'h23: dec_ctrl = OP_SUB;
                    6'h24:        dec_ctrl = OP_AND;
                    6'h25:        dec_ctrl = OP_OR;
                    6'h26:        dec_ctrl = OP_XOR;
                    6'h27:        dec_ctrl = OP_NOR;
                    6'h2A:        dec_ctrl = OP_SLT;
                    6'h2B:        dec_ctrl = OP_SLTU;
                    default: begin
                        dec_rw  = 1'b0;
                        dec_ill = 1'b1;
                    end
                endcase
            end
            6'h08, 6'h09: begin dec_ctrl = OP_ADD;  dec_src = 1'b1; dec_rw = 1'b1; end
            6'h0A:        begin dec_ctrl = OP_SLT;  dec_src = 1'b1; dec_rw = 1'b1; end
            6'h0B:        begin dec_ctrl = OP_SLTU; dec_src = 1'b1; dec_rw = 1'b1; end
            6'h0C:        begin dec_ctrl = OP_AND;  dec_src = 1'b1; dec_rw = 1'b1; end
            6'h0D:        begin dec_ctrl = OP_OR;   dec_src = 1'b1; dec_rw = 1'b1; end
            6'h0E:        begin dec_ctrl = OP_XOR;  dec_src = 1'b1; dec_rw = 1'b1; end
            6'h23:        begin dec_ctrl = OP_ADD;  dec_src = 1'b1; dec_rw = 1'b1; end
            6'h2B:        begin dec_ctrl = OP_ADD;  dec_src = 1'b1; dec_rw = 1'b0; end
            6'h04:        begin dec_ctrl = OP_SUB;  dec_src = 1'b0; dec_rw = 1'b0; end
            default:      dec_ill = 1'b1;
        endcase
    end

    // ID/EX register: reset clears, flush loads a bubble, stall holds, otherwise loads decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_control_e <= 3'b000;
            alu_src_e     <= 1'b0;
            reg_write_e   <= 1'b0;
            valid_e       <= 1'b0;
            illegal_e     <= 1'b0;
        end else if (flush) begin
            alu_control_e <= 3'b000;
            alu_src_e     <= 1'b0;
            reg_write_e   <= 1'b0;
            valid_e       <= 1'b0;
            illegal_e     <= 1'b0;
        end else if (!stall) begin
            if (valid_d) begin
                alu_control_e <= dec_ctrl;
                alu_src_e     <= dec_src;
                reg_write_e   <= dec_rw;
                valid_e       <= 1'b1;
                illegal_e     <= dec_ill;
            end else begin
                alu_control_e <= 3'b000;
                alu_src_e     <= 1'b0;
                reg_write_e   <= 1'b0;
                valid_e       <= 1'b0;
                illegal_e     <= 1'b0;
            end
        end
    end

    // Saturating count of valid illegal instructions loaded into EX; hold and flush never count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_cnt <= '0;
        end else if (!flush && !stall && valid_d && dec_ill && (illegal_cnt != CNT_MAX)) begin
            illegal_cnt <= illegal_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_ctrl_decode_stage.sv
// tb_alu_ctrl_decode_stage
// The stimulus process drives ID inputs on the falling edge. It advances a
// table-driven reference model of the ID/EX register and pushes the expected
// EX state. A monitor pops one entry after every rising edge and compares.
// A second instance with a 2-bit counter exercises saturation.
module tb_alu_ctrl_decode_stage;

    localparam int W = 17;

    logic       clk;
    logic       rst;
    logic [5:0] opcode_d;
    logic [5:0] funct_d;
    logic       valid_d;
    logic       stall;
    logic       flush;

    logic [2:0] alu_control_e;
    logic       alu_src_e;
    logic       reg_write_e;
    logic       valid_e;
    logic       illegal_e;
    logic [7:0] illegal_cnt;

    logic [2:0] s_alu_control_e;
    logic       s_alu_src_e;
    logic       s_reg_write_e;
    logic       s_valid_e;
    logic       s_illegal_e;
    logic [1:0] s_illegal_cnt;

    alu_ctrl_decode_stage #(.CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .opcode_d(opcode_d), .funct_d(funct_d),
        .valid_d(valid_d), .stall(stall), .flush(flush),
        .alu_control_e(alu_control_e), .alu_src_e(alu_src_e),
        .reg_write_e(reg_write_e), .valid_e(valid_e), .illegal_e(illegal_e),
        .illegal_cnt(illegal_cnt)
    );

    alu_ctrl_decode_stage #(.CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .opcode_d(opcode_d), .funct_d(funct_d),
        .valid_d(valid_d), .stall(stall), .flush(flush),
        .alu_control_e(s_alu_control_e), .alu_src_e(s_alu_src_e),
        .reg_write_e(s_reg_write_e), .valid_e(s_valid_e), .illegal_e(s_illegal_e),
        .illegal_cnt(s_illegal_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];

    // reference tables: R-type funct -> op, and other opcodes -> {op, alu_src, reg_write}
    logic [2:0] r_tab[int];
    logic [4:0] i_tab[int];

    // reference EX state
    logic [2:0] m_ctrl;
    logic       m_src, m_rw, m_valid, m_ill;
    int         m_cnt8, m_cnt2;

    function automatic logic [W-1:0] dut_vec();
        return {alu_control_e, alu_src_e, reg_write_e, valid_e, illegal_e,
                illegal_cnt, s_illegal_cnt};
    endfunction

    function automatic logic [W-1:0] model_vec();
        logic [7:0] c8;
        logic [1:0] c2;
        c8 = 8'(m_cnt8);
        c2 = 2'(m_cnt2);
        return {m_ctrl, m_src, m_rw, m_valid, m_ill, c8, c2};
    endfunction

    task automatic check_vec(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got ctrl/src/rw/valid/ill=%b/%b/%b/%b/%b cnt=%0d sat=%0d, expected %b/%b/%b/%b/%b cnt=%0d sat=%0d",
                     name, got[16:14], got[13], got[12], got[11], got[10], got[9:2], got[1:0],
                     exp[16:14], exp[13], exp[12], exp[11], exp[10], exp[9:2], exp[1:0]);
        end
    endtask

    task automatic model_reset();
        m_ctrl = 3'b000; m_src = 1'b0; m_rw = 1'b0; m_valid = 1'b0; m_ill = 1'b0;
        m_cnt8 = 0; m_cnt2 = 0;
    endtask

    task automatic model_bubble();
        m_ctrl = 3'b000; m_src = 1'b0; m_rw = 1'b0; m_valid = 1'b0; m_ill = 1'b0;
    endtask

    // driver: apply inputs now, step the model for the coming rising edge, push expectation
    task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                         input logic v, input logic st, input logic fl);
        opcode_d = op; funct_d = fn; valid_d = v; stall = st; flush = fl;
        if (fl) begin
            model_bubble();
        end else if (!st) begin
            if (!v) begin
                model_bubble();
            end else begin
                m_valid = 1'b1;
                if (op == 6'h00 && r_tab.exists(int'(fn))) begin
                    m_ctrl = r_tab[int'(fn)]; m_src = 1'b0; m_rw = 1'b1; m_ill = 1'b0;
                end else if (op != 6'h00 && i_tab.exists(int'(op))) begin
                    {m_ctrl, m_src, m_rw} = i_tab[int'(op)]; m_ill = 1'b0;
                end else begin
                    m_ctrl = 3'b000; m_src = 1'b0; m_rw = 1'b0; m_ill = 1'b1;
                    if (m_cnt8 < 255) m_cnt8++;
                    if (m_cnt2 < 3) m_cnt2++;
                end
            end
        end
        exp_q.push_back(model_vec());
    endtask

    task automatic cycle(input logic [5:0] op, input logic [5:0] fn,
                         input logic v, input logic st, input logic fl);
        @(negedge clk);
        drive(op, fn, v, st, fl);
    endtask

    // monitor: after every rising edge compare the EX state with the oldest expectation
    initial begin
        logic [W-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_vec("id_ex", dut_vec(), e);
            end
        end
    end

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
        $fatal(1, "timeout");
    end

    logic [5:0] r_fn_list[10];
    logic [5:0] op_list[13];

    initial begin
        logic [5:0] op, fn;
        logic [5:0] sweep_fn[8];
        logic [5:0] it_op[5];

        r_tab[32] = 3'b000; r_tab[33] = 3'b000; r_tab[34] = 3'b001; r_tab[35] = 3'b001;
        r_tab[36] = 3'b010; r_tab[37] = 3'b011; r_tab[38] = 3'b100; r_tab[39] = 3'b101;
        r_tab[42] = 3'b110; r_tab[43] = 3'b111;
        i_tab[8]  = 5'b000_1_1; i_tab[9]  = 5'b000_1_1; i_tab[10] = 5'b110_1_1;
        i_tab[11] = 5'b111_1_1; i_tab[12] = 5'b010_1_1; i_tab[13] = 5'b011_1_1;
        i_tab[14] = 5'b100_1_1; i_tab[35] = 5'b000_1_1; i_tab[43] = 5'b000_1_0;
        i_tab[4]  = 5'b001_0_0;

        r_fn_list = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
        op_list   = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D,
                      6'h0E, 6'h23, 6'h2B, 6'h04};
        sweep_fn  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
        it_op     = '{6'h0A, 6'h0D, 6'h23, 6'h2B, 6'h04};

        // reset
        opcode_d = 6'h00; funct_d = 6'h00; valid_d = 1'b0; stall = 1'b0; flush = 1'b0;
        rst = 1'b1;
        model_reset();
        #1;
        check_vec("reset_state", dut_vec(), model_vec());
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // R-type sweep
        foreach (sweep_fn[i]) cycle(6'h00, sweep_fn[i], 1'b1, 1'b0, 1'b0);
        // I-type / memory / branch
        foreach (it_op[i]) cycle(it_op[i], 6'(i), 1'b1, 1'b0, 1'b0);

        // stall holds through changing inputs, then flush wins over stall
        cycle(6'h0C, 6'h00, 1'b1, 1'b0, 1'b0);
        repeat (3) cycle(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 1'b1, 1'b1, 1'b0);
        cycle(6'h0D, 6'h00, 1'b1, 1'b1, 1'b1);

        // illegal encodings; invalid, stalled and flushed illegal inputs never count
        cycle(6'h00, 6'h3F, 1'b1, 1'b0, 1'b0);
        cycle(6'h3F, 6'h00, 1'b1, 1'b0, 1'b0);
        cycle(6'h3F, 6'h00, 1'b0, 1'b0, 1'b0);
        cycle(6'h00, 6'h3F, 1'b0, 1'b0, 1'b0);
        cycle(6'h3F, 6'h00, 1'b1, 1'b1, 1'b0);
        cycle(6'h3F, 6'h00, 1'b1, 1'b0, 1'b1);
        // saturation of the 2-bit counter
        repeat (5) cycle(6'h1F, 6'h00, 1'b1, 1'b0, 1'b0);
        cycle(6'h00, 6'h20, 1'b1, 1'b0, 1'b0);

        // async reset in the middle of a stall
        cycle(6'h0C, 6'h00, 1'b1, 1'b0, 1'b0);
        cycle(6'h0E, 6'h00, 1'b1, 1'b1, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        check_vec("async_reset", dut_vec(), model_vec());
        @(negedge clk);
        rst = 1'b0;
        drive(6'h0A, 6'h00, 1'b1, 1'b0, 1'b0);

        // randomized traffic
        repeat (400) begin
            if ($urandom_range(0, 3) == 0) op = 6'($urandom_range(0, 63));
            else op = op_list[$urandom_range(0, 12)];
            if (op == 6'h00 && $urandom_range(0, 3) != 0) fn = r_fn_list[$urandom_range(0, 9)];
            else fn = 6'($urandom_range(0, 63));
            cycle(op, fn, ($urandom_range(0, 7) != 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 7) == 0));
        end

        @(posedge clk);
        #3;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
